// File: rtl/vec_addsub_sequencer_if.sv
// rtl/vec_addsub_sequencer_if.sv - instruction, result and adder-port bundle for vec_addsub_sequencer
interface vec_addsub_sequencer_if #(
    parameter int VLEN = 128
);
    localparam int VLW = $clog2(VLEN / 8) + 1;

    logic            in_valid;
    logic            in_ready;
    logic            op_sub;
    logic [1:0]      sew;
    logic [VLW-1:0]  vl;
    logic [VLEN-1:0] vs1;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] vd_old;

    logic            add_ctrl;
    logic            add_sew_16_32;
    logic            add_sew_32;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic [31:0]     add_sum;

    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] vd;
    logic            out_err;

    // master: issue stage plus the SIMD adder; slave: the sequencer
    modport master (
        output in_valid, op_sub, sew, vl, vs1, vs2, vd_old, out_ready, add_sum,
        input  in_ready, out_valid, vd, out_err, add_ctrl, add_sew_16_32, add_sew_32, add_a, add_b
    );

    modport slave (
        input  in_valid, op_sub, sew, vl, vs1, vs2, vd_old, out_ready, add_sum,
        output in_ready, out_valid, vd, out_err, add_ctrl, add_sew_16_32, add_sew_32, add_a, add_b
    );
endinterface

// File: rtl/vec_addsub_sequencer.sv
// rtl/vec_addsub_sequencer.sv - walks a vector add/sub through a 32-bit SIMD adder, tail-undisturbed merge
// Optional: VADDSUB_EARLY_EXIT_EN stops after the last chunk holding an active element.
module vec_addsub_sequencer #(
    parameter int VLEN = 128
) (
    input logic                    clk,
    input logic                    reset,
    vec_addsub_sequencer_if.slave  bus
);
    localparam int NCHUNK = VLEN / 32;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int VLW    = $clog2(VLEN / 8) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_last;
    logic [1:0]      sew_q;
    logic [VLW-1:0]  vl_q;
    logic [VLEN-1:0] vs1_q;
    logic [VLEN-1:0] vs2_q;
    logic [VLEN-1:0] vd_q;
    logic            out_valid_q;
    logic            out_err_q;
    logic [31:0]     add_a_q;
    logic [31:0]     add_b_q;
    logic            add_ctrl_q;
    logic            add_sew_16_32_q;
    logic            add_sew_32_q;

    logic [VLW-1:0]  vlmax_in;
    logic [VLW-1:0]  vl_clamp_in;
    logic [KW-1:0]   k_last_in;
    logic [VLEN-1:0] vd_next;
    logic [31:0]     byte_idx;
    logic [31:0]     elem_idx;

    always_comb begin
        vlmax_in    = VLW'((VLEN / 8) >> bus.sew);
        vl_clamp_in = (bus.vl > vlmax_in) ? vlmax_in : bus.vl;
    end

`ifdef VADDSUB_EARLY_EXIT_EN
    logic [31:0] act_bits;
    logic [31:0] n_chunks;

    // chunks needed = ceil(active bits / 32); only used when at least one element is active
    always_comb begin
        act_bits  = 32'(vl_clamp_in) << ({3'b000, bus.sew} + 5'd3);
        n_chunks  = (act_bits + 32'd31) >> 5;
        k_last_in = KW'(n_chunks - 32'd1);
    end
`else
    always_comb begin
        k_last_in = KW'(NCHUNK - 1);
    end
`endif

    // vd_q already holds vd_old, so tail bytes simply keep their value
    always_comb begin
        vd_next  = vd_q;
        byte_idx = '0;
        elem_idx = '0;
        for (int j = 0; j < 4; j++) begin
            byte_idx = (32'(k) << 2) + 32'(j);
            elem_idx = byte_idx >> sew_q;
            if (elem_idx < 32'(vl_q)) begin
                vd_next[32*k + 8*j +: 8] = bus.add_sum[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            k               <= '0;
            k_last          <= '0;
            sew_q           <= 2'b00;
            vl_q            <= '0;
            vs1_q           <= '0;
            vs2_q           <= '0;
            vd_q            <= '0;
            out_valid_q     <= 1'b0;
            out_err_q       <= 1'b0;
            add_a_q         <= '0;
            add_b_q         <= '0;
            add_ctrl_q      <= 1'b0;
            add_sew_16_32_q <= 1'b0;
            add_sew_32_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sew_q     <= bus.sew;
                        vl_q      <= vl_clamp_in;
                        vs1_q     <= bus.vs1;
                        vs2_q     <= bus.vs2;
                        vd_q      <= bus.vd_old;
                        k         <= '0;
                        k_last    <= k_last_in;
                        out_err_q <= 1'b0;
                        if (bus.sew == 2'b11) begin
                            out_err_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
`ifdef VADDSUB_EARLY_EXIT_EN
                        end else if (vl_clamp_in == '0) begin
                            out_valid_q <= 1'b1;
                            state       <= DONE;
`endif
                        end else begin
                            // adder ports are registered, so chunk 0 is presented from the accept edge
                            add_a_q         <= bus.vs2[31:0];
                            add_b_q         <= bus.vs1[31:0];
                            add_ctrl_q      <= bus.op_sub;
                            add_sew_16_32_q <= (bus.sew != 2'b00);
                            add_sew_32_q    <= (bus.sew == 2'b10);
                            state           <= RUN;
                        end
                    end
                end
                RUN: begin
                    vd_q <= vd_next;
                    if (k == k_last) begin
                        add_a_q         <= '0;
                        add_b_q         <= '0;
                        add_ctrl_q      <= 1'b0;
                        add_sew_16_32_q <= 1'b0;
                        add_sew_32_q    <= 1'b0;
                        out_valid_q     <= 1'b1;
                        state           <= DONE;
                    end else begin
                        add_a_q <= vs2_q[32*(k + 1'b1) +: 32];
                        add_b_q <= vs1_q[32*(k + 1'b1) +: 32];
                        k       <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE) && !reset;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_err       = out_err_q;
    assign bus.vd            = vd_q;
    assign bus.add_a         = add_a_q;
    assign bus.add_b         = add_b_q;
    assign bus.add_ctrl      = add_ctrl_q;
    assign bus.add_sew_16_32 = add_sew_16_32_q;
    assign bus.add_sew_32    = add_sew_32_q;
endmodule

// File: tb/tb_vec_addsub_sequencer.sv
// tb/tb_vec_addsub_sequencer.sv - scoreboard bench for vec_addsub_sequencer with a segmented-adder model
module tb_vec_addsub_sequencer;
    typedef struct {
        logic [127:0] vd;
        logic         err;
        int           lat;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    longint cyc = 0;
    longint accept_cyc = 0;
    int     checks = 0;
    int     failures = 0;
    exp_t   sb[$];
    logic [127:0] last_vd;

    vec_addsub_sequencer_if #(.VLEN(128)) bus ();

    vec_addsub_sequencer #(.VLEN(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b,
                                                input logic sub, input logic s1632, input logic s32);
        logic [31:0] r;
        r = '0;
        if (s32) begin
            r = sub ? a - b : a + b;
        end else if (s1632) begin
            for (int h = 0; h < 2; h++)
                r[16*h +: 16] = sub ? a[16*h +: 16] - b[16*h +: 16] : a[16*h +: 16] + b[16*h +: 16];
        end else begin
            for (int h = 0; h < 4; h++)
                r[8*h +: 8] = sub ? a[8*h +: 8] - b[8*h +: 8] : a[8*h +: 8] + b[8*h +: 8];
        end
        return r;
    endfunction

    assign bus.add_sum = adder_model(bus.add_a, bus.add_b, bus.add_ctrl, bus.add_sew_16_32, bus.add_sew_32);

    function automatic logic [127:0] ref_vd(input logic op, input logic [1:0] s, input logic [4:0] l,
                                            input logic [127:0] a1, input logic [127:0] a2, input logic [127:0] old);
        logic [127:0] r;
        logic [31:0]  x, y, z;
        int esz, n;
        r = old;
        if (s == 2'b11) return r;
        esz = 8 << s;
        n = 128 / esz;
        if (int'(l) < n) n = int'(l);
        for (int e = 0; e < n; e++) begin
            x = '0;
            y = '0;
            for (int i = 0; i < esz; i++) begin
                x[i] = a2[e*esz + i];
                y[i] = a1[e*esz + i];
            end
            z = op ? x - y : x + y;
            for (int i = 0; i < esz; i++) r[e*esz + i] = z[i];
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] s, input logic [4:0] l);
        int n, ch;
        if (s == 2'b11) return 1;
        n = 16 >> s;
        if (int'(l) < n) n = int'(l);
        ch = (n * (8 << s) + 31) / 32;
`ifdef VADDSUB_EARLY_EXIT_EN
        return (ch == 0) ? 1 : ch + 1;
`else
        return (ch >= 0) ? 5 : 5;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic op, input logic [1:0] s, input logic [4:0] l,
                         input logic [127:0] a1, input logic [127:0] a2, input logic [127:0] old);
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", 128'(bus.in_ready), 128'(1));
        bus.op_sub   = op;
        bus.sew      = s;
        bus.vl       = l;
        bus.vs1      = a1;
        bus.vs2      = a2;
        bus.vd_old   = old;
        bus.in_valid = 1'b1;
        e.vd  = ref_vd(op, s, l, a1, a2, old);
        e.err = (s == 2'b11);
        e.lat = exp_lat(s, l);
        sb.push_back(e);
        @(posedge clk);
        #1;
        accept_cyc   = cyc;
        bus.in_valid = 1'b0;
        bus.vs1      = ~a1;
        bus.vs2      = ~a2;
        bus.vd_old   = ~old;
        bus.op_sub   = ~op;
    endtask

    task automatic wait_result(input string tag, input bit ack);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_out_valid"}, 128'(seen), 128'(1));
        e = sb.pop_front();
        last_vd = e.vd;
        if (seen) begin
            check({tag, "_latency"}, 128'(int'(cyc - accept_cyc) + 1), 128'(e.lat));
            check({tag, "_vd"}, bus.vd, e.vd);
            check({tag, "_err"}, 128'(bus.out_err), 128'(e.err));
        end
        if (ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] aa;
        logic [127:0] r1, r2, r3;
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.sew       = 2'b00;
        bus.vl        = '0;
        bus.vs1       = '0;
        bus.vs2       = '0;
        bus.vd_old    = '0;
        bus.out_ready = 1'b0;
        aa = {32{4'hA}};

        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_err", 128'(bus.out_err), 128'(0));
        check("rst_vd", bus.vd, 128'(0));
        check("rst_adder", {bus.add_a, bus.add_b, 29'(0), bus.add_ctrl, bus.add_sew_16_32, bus.add_sew_32}, 128'(0));
        reset = 1'b0;

        issue(1'b0, 2'b00, 5'd16, {16{8'h01}}, {16{8'h7F}}, '0);
        wait_result("sew8_add", 1'b1);
        check("sew8_add_const", last_vd, {16{8'h80}});

        issue(1'b1, 2'b01, 5'd8, {8{16'h0001}}, '0, aa);
        @(negedge clk);
        check("sew16_run_mode", {125'(0), bus.add_ctrl, bus.add_sew_16_32, bus.add_sew_32}, 128'(3'b110));
        check("sew16_run_ops", {64'(0), bus.add_a, bus.add_b}, {64'(0), 32'h0, 32'h00010001});
        wait_result("sew16_sub", 1'b1);
        check("sew16_sub_const", last_vd, {8{16'hFFFF}});

        issue(1'b0, 2'b10, 5'd3, {4{32'h00000002}}, {4{32'hFFFFFFFF}}, aa);
        wait_result("sew32_vl3", 1'b1);
        check("sew32_vl3_const", last_vd, {32'hAAAAAAAA, {3{32'h00000001}}});

        issue(1'b0, 2'b11, 5'd4, {4{32'h12345678}}, {4{32'h9ABCDEF0}}, aa);
        wait_result("sew_illegal", 1'b0);
        check("sew_illegal_adder_idle", {bus.add_a, bus.add_b, 29'(0), bus.add_ctrl, bus.add_sew_16_32, bus.add_sew_32}, 128'(0));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        issue(1'b0, 2'b00, 5'd0, {4{32'h11111111}}, {4{32'h22222222}}, aa);
        wait_result("vl_zero", 1'b1);

        issue(1'b1, 2'b10, 5'd16, {4{32'h00000005}}, {32'd1, 32'd2, 32'd3, 32'd4}, aa);
        wait_result("vl_clamp", 1'b1);

        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        issue(1'b0, 2'b01, 5'd5, r1, r2, aa);
        wait_result("backpressure", 1'b0);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.sew      = 2'b11;
            bus.vd_old   = '0;
            @(negedge clk);
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check("bp_vd_stable", bus.vd, last_vd);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_released", 128'(bus.out_valid), 128'(0));
        issue(1'b1, 2'b00, 5'd11, r2, r1, aa);
        wait_result("after_bp", 1'b1);

        issue(1'b0, 2'b00, 5'd16, r1, r2, aa);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_vd", bus.vd, 128'(0));
        check("abort_in_ready", 128'(bus.in_ready), 128'(0));
        check("abort_adder", {96'(0), bus.add_a}, 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle", 128'(bus.in_ready), 128'(1));
        issue(1'b0, 2'b10, 5'd4, r2, r1, aa);
        wait_result("after_abort", 1'b1);

        for (int t = 0; t < 6; t++) begin
            r3 = {$urandom, $urandom, $urandom, $urandom};
            issue(1'($urandom_range(1)), 2'($urandom_range(2)), 5'($urandom_range(20)), r1 ^ r3, r2 + r3, r3);
            wait_result("random", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vec_addsub_sequencer.md
# vec_addsub_sequencer

Issue-side driver for the packed 32-bit SIMD adder/subtractor in the vector execution unit. It accepts a whole vector add/sub instruction: two VLEN-bit source registers, the old destination value, SEW, vl and the add/sub selector. It walks the operands through the adder one 32-bit chunk per cycle and drives the adder's control and operand inputs. It merges each returned sum into the destination under a vl-based tail mask (tail elements undisturbed), then returns the result through a valid/ready handshake.

## Interface
- VLEN, 128, vector register width in bits; must be a multiple of 32 and at least 32.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  high only in IDLE with reset low.
- op_sub  input  1  0 = add, 1 = subtract (vs2 − vs1).
- sew  input  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
- vl  input  $clog2(VLEN/8)+1  active element count.
- vs1, vs2, vd_old  input  VLEN  operands and prior destination.
- add_ctrl  output  1  connects to the adder's Ctrl input.
- add_sew_16_32  output  1  connects to the adder's sew_16_32 input.
- add_sew_32  output  1  connects to the adder's sew_32 input.
- add_a, add_b  output  32  adder operands; add_a = vs2 chunk, add_b = vs1 chunk.
- add_sum  input  32  adder result, same cycle (combinational path).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- vd  output  VLEN  merged result.
- out_err  output  1  illegal sew flag, qualified by out_valid.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on in_valid && in_ready:
  - register op_sub, sew, vs1, vs2 and vd_old;
  - clamp vl to VLMAX = VLEN/SEW;
  - preload vd ← vd_old;
  - clear the chunk counter k.
- IDLE → DONE directly when sew = 11 at accept: vd = vd_old, out_err = 1.
- In RUN, every cycle:
  - drive add_a = vs2[32k +: 32], add_b = vs1[32k +: 32], add_ctrl = op_sub;
  - for each byte lane of chunk k: if its element index < clamped vl, vd byte ← add_sum byte, else keep vd_old byte;
  - then k ← k+1.
- Adder mode encoding:
  - SEW8: add_sew_16_32 = 0, add_sew_32 = 0;
  - SEW16: add_sew_16_32 = 1, add_sew_32 = 0;
  - SEW32: add_sew_16_32 = 1, add_sew_32 = 1.
- Arithmetic is modulo 2^SEW per element. No carry crosses an element boundary; the adder segmentation guarantees this. No saturation, no flags.
- RUN → DONE after the last chunk, k = VLEN/32 − 1 (or earlier, see Configuration).
- DONE: out_valid = 1; vd and out_err held stable. DONE → IDLE on out_ready.
- Outside RUN: add_a = add_b = 0 and add_ctrl = add_sew_16_32 = add_sew_32 = 0.
- in_valid is ignored when not in IDLE. Operand inputs need to be valid only in the accept cycle.

## Timing
- Accept at edge t. Chunk cycles occupy t+1 … t+C, with C = VLEN/32 by default. out_valid rises after the edge ending cycle t+C.
- Total latency C+1 cycles; C = 4 for VLEN = 128.
- Throughput: one instruction per C+2 cycles minimum. in_ready is low from accept until the DONE→IDLE edge (no overlap).
- out_valid, vd and out_err are registered. in_ready is combinational from state and reset.
- Reset values: state IDLE, out_valid 0, out_err 0, vd 0, k 0, all adder outputs 0; in_ready 0 while reset is high.
- Reset in RUN or DONE: abort and return to IDLE at that edge. No result is emitted and partial vd is discarded.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- vl = 0 with legal sew: all elements are tail, so vd = vd_old and out_err = 0.

## Configuration
- VADDSUB_EARLY_EXIT_EN:
  - Defined: C = ceil(clamped_vl × SEW / 32). RUN ends after the last chunk holding an active element. Unvisited chunks keep vd_old. vl = 0 goes IDLE → DONE directly (latency 1).
  - Undefined: C is always VLEN/32, regardless of vl.

## Test plan
- VLEN = 128, sew = 00, vl = 16, add; vs2 bytes 0x7F, vs1 bytes 0x01 → vd = 16×0x80 (no inter-byte carry); out_valid after 5 cycles.
- sew = 01, vl = 8, sub; vs2 = 0, vs1 halfwords 0x0001 → vd halfwords all 0xFFFF; add_sew_16_32 = 1 and add_sew_32 = 0 during RUN.
- sew = 10, vl = 3, add; vs2 words 0xFFFFFFFF, vs1 words 0x00000002, vd_old = 0xAAAA… → words 0–2 = 0x00000001, word 3 = 0xAAAAAAAA. With VADDSUB_EARLY_EXIT_EN, latency is 4.
- sew = 11 → out_err = 1, vd = vd_old, out_valid on the cycle after accept; no adder activity.
- Hold out_ready = 0 for 6 cycles in DONE → vd stable, in_ready = 0, a second in_valid is ignored; accepted after the handshake completes.
- Assert reset at RUN chunk 2 → next cycle out_valid = 0, vd = 0, IDLE; a new instruction then completes normally.
